// File: rtl/alu_issue_seq.sv
// ---------------------------------------------------------------------------
// alu_issue_seq
//
// Issue sequencer sitting directly in front of the execute datapath
// (ALU / shifter / MULTU / HiLo / result mux). One R-type operation is
// accepted at a time, its operands and funct are held on the execute-stage
// inputs for the full latency of the op, and the execute Output is captured
// and offered downstream over a valid/ready handshake.
//
// Because only one op is ever in flight and a MULTU occupies the sequencer
// for MUL_LAT cycles, a later MFHI/MFLO can never observe HiLo mid-multiply.
//
// Parameters:
//   COMB_LAT  cycles from issue to stable Output for single-cycle-class ops
//             (AND/OR/ADD/SUB/SLT/SLL/MFHI/MFLO), legal range 1..15
//   MUL_LAT   cycles from MULTU issue until HiLo holds the product,
//             legal range 2..63
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_valid     request valid
//   in_ready     sequencer can accept a request (IDLE)
//   in_dataA     operand A
//   in_dataB     operand B
//   in_funct     6-bit funct code
//   dataA        operand A driven to the execute stage
//   dataB        operand B driven to the execute stage
//   Signal       funct driven to the execute stage
//   alu_result   execute-stage Output
//   out_valid    result valid (RESP)
//   out_ready    downstream accepts the result
//   out_result   captured result (0 for MULTU and illegal)
//   out_funct    funct of the completed op
//   out_wb       result is a register write
//   out_illegal  funct was not recognised
//   busy         sequencer is not IDLE
//
// Optional feature (macro ALU_ISSUE_SEQ_PERF_EN):
//   perf_ops     completed handshakes
//   perf_mul     completed MULTU ops
//   perf_stall   cycles with out_valid & !out_ready
//   All three clear on reset and wrap modulo 2^32.
// ---------------------------------------------------------------------------
module alu_issue_seq #(
  parameter int unsigned COMB_LAT = 1,
  parameter int unsigned MUL_LAT  = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_dataA,
  input  logic [31:0] in_dataB,
  input  logic [5:0]  in_funct,
  output logic [31:0] dataA,
  output logic [31:0] dataB,
  output logic [5:0]  Signal,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [5:0]  out_funct,
  output logic        out_wb,
  output logic        out_illegal,
  output logic        busy
`ifdef ALU_ISSUE_SEQ_PERF_EN
  ,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_mul,
  output logic [31:0] perf_stall
`endif
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_SLT   = 6'd42;

  // The counter is loaded with latency-1 so that the cycle in which it reads
  // zero is the last EXEC cycle; this gives exactly LAT cycles of occupancy.
  localparam logic [5:0] COMB_CNT = 6'(COMB_LAT - 1);
  localparam logic [5:0] MUL_CNT  = 6'(MUL_LAT - 1);

  // What the execute stage sees whenever nothing is in flight. ADD is
  // harmless; MULTU must never appear here since it would disturb HiLo.
  localparam logic [31:0] IDLE_DATA  = 32'd0;
  localparam logic [5:0]  IDLE_FUNCT = FN_ADD;

  // -------------------------------------------------------------------------
  // funct decode
  // -------------------------------------------------------------------------
  function automatic logic funct_legal(input logic [5:0] f);
    logic ok;
    ok = 1'b0;
    case (f)
      FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT,
      FN_SLL, FN_MULTU, FN_MFHI, FN_MFLO: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic in_legal;
  logic in_is_mul;
  logic exec_is_mul;

  assign in_legal    = funct_legal(in_funct);
  assign in_is_mul   = (in_funct == FN_MULTU);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [1:0]  state_q,    state_d;
  logic [5:0]  cnt_q,      cnt_d;
  logic [31:0] data_a_q,   data_a_d;
  logic [31:0] data_b_q,   data_b_d;
  logic [5:0]  signal_q,   signal_d;
  logic [31:0] res_q,      res_d;
  logic [5:0]  ofunct_q,   ofunct_d;
  logic        wb_q,       wb_d;
  logic        illegal_q,  illegal_d;

  assign exec_is_mul = (signal_q == FN_MULTU);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_a_d  = data_a_q;
    data_b_d  = data_b_q;
    signal_d  = signal_q;
    res_d     = res_q;
    ofunct_d  = ofunct_q;
    wb_d      = wb_q;
    illegal_d = illegal_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_legal) begin
            data_a_d = in_dataA;
            data_b_d = in_dataB;
            signal_d = in_funct;
            cnt_d    = in_is_mul ? MUL_CNT : COMB_CNT;
            state_d  = ST_EXEC;
          end else begin
            // Illegal ops never touch the execute stage; the response is
            // formed here directly and the operand drive stays idle.
            res_d     = 32'd0;
            ofunct_d  = in_funct;
            wb_d      = 1'b0;
            illegal_d = 1'b1;
            state_d   = ST_RESP;
          end
        end
      end

      ST_EXEC: begin
        if (cnt_q == 6'd0) begin
          // MULTU produces nothing on the result bus; its product lives in
          // HiLo and is fetched by a later MFHI/MFLO.
          res_d     = exec_is_mul ? 32'd0 : alu_result;
          ofunct_d  = signal_q;
          wb_d      = !exec_is_mul;
          illegal_d = 1'b0;
          data_a_d  = IDLE_DATA;
          data_b_d  = IDLE_DATA;
          signal_d  = IDLE_FUNCT;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end

      ST_RESP: begin
        // The response registers are only written in IDLE/EXEC, so they
        // are naturally stable for any length of back-pressure.
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        cnt_d    = 6'd0;
        data_a_d = IDLE_DATA;
        data_b_d = IDLE_DATA;
        signal_d = IDLE_FUNCT;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 6'd0;
      data_a_q  <= IDLE_DATA;
      data_b_q  <= IDLE_DATA;
      signal_q  <= IDLE_FUNCT;
      res_q     <= 32'd0;
      ofunct_q  <= 6'd0;
      wb_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      signal_q  <= signal_d;
      res_q     <= res_d;
      ofunct_q  <= ofunct_d;
      wb_q      <= wb_d;
      illegal_q <= illegal_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_RESP);
  assign busy        = (state_q != ST_IDLE);
  assign dataA       = data_a_q;
  assign dataB       = data_b_q;
  assign Signal      = signal_q;
  assign out_result  = res_q;
  assign out_funct   = ofunct_q;
  assign out_wb      = wb_q;
  assign out_illegal = illegal_q;

`ifdef ALU_ISSUE_SEQ_PERF_EN
  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
  logic [31:0] perf_ops_q,   perf_ops_d;
  logic [31:0] perf_mul_q,   perf_mul_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        out_fire;

  assign out_fire = out_valid & out_ready;

  always_comb begin
    perf_ops_d   = perf_ops_q;
    perf_mul_d   = perf_mul_q;
    perf_stall_d = perf_stall_q;
    if (out_fire) begin
      perf_ops_d = perf_ops_q + 32'd1;
      // MULTU is a legal code, so out_funct alone identifies it.
      if (ofunct_q == FN_MULTU) begin
        perf_mul_d = perf_mul_q + 32'd1;
      end
    end
    if (out_valid && !out_ready) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ops_q   <= 32'd0;
      perf_mul_q   <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      perf_ops_q   <= perf_ops_d;
      perf_mul_q   <= perf_mul_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_mul   = perf_mul_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_seq
//
// Self-checking bench for alu_issue_seq. A small behavioural execute stage
// (ALU, shifter, MULTU into HiLo, MFHI/MFLO) answers the sequencer's drive.
// Directed table vectors plus randomized ops are checked against a
// transaction-level reference (expected result, flags and latency per op).
// ---------------------------------------------------------------------------
module tb_alu_issue_seq;

  localparam int COMB_LAT = 1;
  localparam int MUL_LAT  = 33;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_dataA;
  logic [31:0] in_dataB;
  logic [5:0]  in_funct;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [5:0]  out_funct;
  logic        out_wb;
  logic        out_illegal;
  logic        busy;
`ifdef ALU_ISSUE_SEQ_PERF_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_mul;
  logic [31:0] perf_stall;
`endif

  int checks;
  int failures;

  alu_issue_seq #(
    .COMB_LAT (COMB_LAT),
    .MUL_LAT  (MUL_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dataA    (in_dataA),
    .in_dataB    (in_dataB),
    .in_funct    (in_funct),
    .dataA       (dataA),
    .dataB       (dataB),
    .Signal      (Signal),
    .alu_result  (alu_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_funct   (out_funct),
    .out_wb      (out_wb),
    .out_illegal (out_illegal),
    .busy        (busy)
`ifdef ALU_ISSUE_SEQ_PERF_EN
    ,
    .perf_ops    (perf_ops),
    .perf_mul    (perf_mul),
    .perf_stall  (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Behavioural execute stage (environment)
  // -------------------------------------------------------------------------
  logic [31:0] hi_m, lo_m;
  int          mul_cyc;

  always @(posedge clk) begin
    if (reset) begin
      hi_m    <= 32'd0;
      lo_m    <= 32'd0;
      mul_cyc <= 0;
    end else if (Signal == 6'd25) begin
      if (mul_cyc == MUL_LAT - 1) {hi_m, lo_m} <= 64'(dataA) * 64'(dataB);
      mul_cyc <= mul_cyc + 1;
    end else begin
      mul_cyc <= 0;
    end
  end

  always_comb begin
    alu_result = 32'd0;
    case (Signal)
      6'd36: alu_result = dataA & dataB;
      6'd37: alu_result = dataA | dataB;
      6'd32: alu_result = dataA + dataB;
      6'd34: alu_result = dataA - dataB;
      6'd42: alu_result = {31'd0, $signed(dataA) < $signed(dataB)};
      6'd0:  alu_result = dataB << dataA[4:0];
      6'd16: alu_result = hi_m;
      6'd18: alu_result = lo_m;
      default: alu_result = 32'd0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Transaction-level reference
  // -------------------------------------------------------------------------
  logic [31:0] ref_hi, ref_lo;
  logic [5:0]  legal_f [9] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42,
                               6'd0, 6'd25, 6'd16, 6'd18};

  function automatic bit is_legal(input logic [5:0] f);
    for (int i = 0; i < 9; i++) if (legal_f[i] == f) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic [5:0] f);
    logic [4:0] sh;
    sh = a[4:0];
    case (f)
      6'd36: return a & b;
      6'd37: return a | b;
      6'd32: return a + b;
      6'd34: return a - b;
      6'd42: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd0:  return b << sh;
      6'd16: return ref_hi;
      6'd18: return ref_lo;
      default: return 32'd0;
    endcase
  endfunction

  // Edges between the accept edge and the first cycle out_valid is seen.
  function automatic int ref_wait(input logic [5:0] f);
    if (!is_legal(f)) return 0;
    if (f == 6'd25) return MUL_LAT;
    return COMB_LAT;
  endfunction

  task automatic ref_retire(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
    if (f == 6'd25) {ref_hi, ref_lo} = 64'(a) * 64'(b);
  endtask

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset  = 1'b0;
    ref_hi = 32'd0;
    ref_lo = 32'd0;
  endtask

  // Runs one op end to end. Called at #1 after a rising edge while IDLE.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] f, input int stall, input logic [31:0] exp_r,
                       input logic exp_wb, input logic exp_ill, input int exp_wait);
    int n, hold_err, stall_err;
    logic [31:0] ea, eb;
    logic [5:0]  ef;
    ea = exp_ill ? 32'd0 : a;
    eb = exp_ill ? 32'd0 : b;
    ef = exp_ill ? 6'd32 : f;

    chk({tag, " in_ready_before"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_dataA = a;
    in_dataB = b;
    in_funct = f;
    @(posedge clk);
    #1;
    // Keep a different request asserted while busy; it must be ignored.
    in_dataA = $urandom;
    in_dataB = $urandom;
    in_funct = 6'd34;

    n = 0;
    hold_err = 0;
    while (!out_valid && n <= MUL_LAT + 8) begin
      if (in_ready !== 1'b0 || dataA !== ea || dataB !== eb || Signal !== ef) hold_err++;
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: out_valid stayed 0 for %0d cycles", tag, n);
      do_reset(2);
      return;
    end
    chk({tag, " latency"}, 64'(n), 64'(exp_wait));
    chk({tag, " operand_hold"}, 64'(hold_err), 64'd0);
    chk({tag, " idle_Signal"}, 64'(Signal), 64'd32);
    chk({tag, " idle_data"}, {dataA, dataB}, 64'd0);
    chk({tag, " out_result"}, 64'(out_result), 64'(exp_r));
    chk({tag, " out_funct"}, 64'(out_funct), 64'(f));
    chk({tag, " out_wb"}, 64'(out_wb), 64'(exp_wb));
    chk({tag, " out_illegal"}, 64'(out_illegal), 64'(exp_ill));
    chk({tag, " busy_resp"}, {62'd0, busy, in_ready}, 64'd2);

    stall_err = 0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || out_result !== exp_r || out_funct !== f ||
          out_wb !== exp_wb || out_illegal !== exp_ill) stall_err++;
    end
    chk({tag, " backpressure_hold"}, 64'(stall_err), 64'd0);

    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, " out_valid_after_hs"}, 64'(out_valid), 64'd0);
    chk({tag, " in_ready_after_hs"}, 64'(in_ready), 64'd1);
    $display("op %s funct=%0d a=%h b=%h result=%h wb=%0d illegal=%0d wait=%0d stall=%0d",
             tag, f, a, b, out_result, out_wb, out_illegal, n, stall);
  endtask

  // -------------------------------------------------------------------------
  // Directed table
  // -------------------------------------------------------------------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  f;
    int          stall;
    logic [31:0] exp_r;
    logic        exp_wb;
    logic        exp_ill;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [31:0] ra, rb, rr;
    logic [5:0]  rf;
    int          rs, bad;
    bit          ill;

    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_dataA  = 32'd0;
    in_dataB  = 32'd0;
    in_funct  = 6'd0;
    out_ready = 1'b0;
    ref_hi    = 32'd0;
    ref_lo    = 32'd0;

    tbl[0]  = '{32'd5,        32'd7,        6'd32, 0,  32'd12,       1'b1, 1'b0};
    tbl[1]  = '{32'hFFFFFFFF, 32'd2,        6'd25, 0,  32'd0,        1'b0, 1'b0};
    tbl[2]  = '{32'd0,        32'd0,        6'd18, 0,  32'hFFFFFFFE, 1'b1, 1'b0};
    tbl[3]  = '{32'd0,        32'd0,        6'd16, 0,  32'd1,        1'b1, 1'b0};
    tbl[4]  = '{32'd3,        32'd5,        6'd34, 10, 32'hFFFFFFFE, 1'b1, 1'b0};
    tbl[5]  = '{32'h1234,     32'h5678,     6'd63, 0,  32'd0,        1'b0, 1'b1};
    tbl[6]  = '{32'hF0F0F0F0, 32'hFF00FF00, 6'd36, 1,  32'hF000F000, 1'b1, 1'b0};
    tbl[7]  = '{32'h0F0F0000, 32'h000000F0, 6'd37, 0,  32'h0F0F00F0, 1'b1, 1'b0};
    tbl[8]  = '{32'hFFFFFFFF, 32'd1,        6'd42, 0,  32'd1,        1'b1, 1'b0};
    tbl[9]  = '{32'd1,        32'hFFFFFFFF, 6'd42, 2,  32'd0,        1'b1, 1'b0};
    tbl[10] = '{32'd4,        32'd3,        6'd0,  0,  32'h30,       1'b1, 1'b0};

    // Reset state
    do_reset(3);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst dataA", 64'(dataA), 64'd0);
    chk("rst dataB", 64'(dataB), 64'd0);
    chk("rst Signal", 64'(Signal), 64'd32);
    chk("rst out_result", 64'(out_result), 64'd0);
    chk("rst out_funct", 64'(out_funct), 64'd0);
    chk("rst out_wb", 64'(out_wb), 64'd0);
    chk("rst out_illegal", 64'(out_illegal), 64'd0);

    for (int i = 0; i < 11; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].f, tbl[i].stall,
            tbl[i].exp_r, tbl[i].exp_wb, tbl[i].exp_ill, ref_wait(tbl[i].f));
      ref_retire(tbl[i].a, tbl[i].b, tbl[i].f);
    end

    // Reset 10 cycles into a MULTU: the op is dropped without a result.
    in_valid = 1'b1;
    in_dataA = 32'd7;
    in_dataB = 32'd9;
    in_funct = 6'd25;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("midmul busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    ref_hi = 32'd0;
    ref_lo = 32'd0;
    chk("midmul_rst out_valid", 64'(out_valid), 64'd0);
    chk("midmul_rst busy", 64'(busy), 64'd0);
    chk("midmul_rst Signal", 64'(Signal), 64'd32);
    chk("midmul_rst in_ready", 64'(in_ready), 64'd1);
    chk("midmul_rst data", {dataA, dataB}, 64'd0);
    bad = 0;
    repeat (MUL_LAT + 5) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) bad++;
    end
    chk("midmul no_stray_result", 64'(bad), 64'd0);
    do_op("post_rst_add", 32'd1, 32'd1, 6'd32, 0, 32'd2, 1'b1, 1'b0, COMB_LAT);

    // Randomized ops against the reference
    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        ra = 32'($urandom_range(0, 40));
        rb = 32'($urandom_range(0, 40));
      end
      if ($urandom_range(0, 7) == 0) begin
        do rf = 6'($urandom_range(0, 63)); while (is_legal(rf));
      end else begin
        rf = legal_f[$urandom_range(0, 8)];
      end
      rs  = $urandom_range(0, 3);
      ill = !is_legal(rf);
      rr  = ref_result(ra, rb, rf);
      do_op($sformatf("rnd%0d", k), ra, rb, rf, rs, rr,
            !ill && rf != 6'd25, ill, ref_wait(rf));
      ref_retire(ra, rb, rf);
    end

`ifdef ALU_ISSUE_SEQ_PERF_EN
    do_reset(2);
    chk("perf_rst ops", 64'(perf_ops), 64'd0);
    do_op("perf_add", 32'd2, 32'd3, 6'd32, 2, 32'd5, 1'b1, 1'b0, COMB_LAT);
    do_op("perf_mul", 32'd6, 32'd7, 6'd25, 0, 32'd0, 1'b0, 1'b0, MUL_LAT);
    ref_retire(32'd6, 32'd7, 6'd25);
    do_op("perf_mflo", 32'd0, 32'd0, 6'd18, 2, 32'd42, 1'b1, 1'b0, COMB_LAT);
    chk("perf_ops", 64'(perf_ops), 64'd3);
    chk("perf_mul", 64'(perf_mul), 64'd1);
    chk("perf_stall", 64'(perf_stall), 64'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
